// File: rtl/spi_master_ctrl_pkg.sv
// spi_master_ctrl_pkg: FSM state encodings, SPI mode and default sizing
// shared by the SPI master and its bench.
package spi_master_ctrl_pkg;
  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LEAD  = 3'd1,
    S_SHIFT = 3'd2,
    S_TRAIL = 3'd3,
    S_GAP   = 3'd4
  } state_t;
  localparam logic [1:0] SPI_MODE0   = 2'b00;
  localparam int         DEF_DATA_W  = 8;
  localparam int         DEF_CLK_DIV = 4;
endpackage

// File: rtl/spi_clk_div.sv
// spi_clk_div: half-period counter producing tick/rise/fall strobes and the
// sclk level; everything clears while disabled.
module spi_clk_div #(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_en,
  input  logic i_shift,
  output logic o_tick,
  output logic o_rise_stb,
  output logic o_fall_stb,
  output logic o_sclk
);
  localparam int CW = $clog2(CLK_DIV + 1);
  logic [CW-1:0] r_cnt;
  logic          r_sclk;
  logic          w_tick;
  assign w_tick     = i_en && (r_cnt == CW'(CLK_DIV - 1));
  assign o_tick     = w_tick;
  assign o_rise_stb = w_tick && i_shift && !r_sclk;
  assign o_fall_stb = w_tick && i_shift && r_sclk;
  assign o_sclk     = r_sclk;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt  <= '0;
      r_sclk <= 1'b0;
    end else if (!i_en) begin
      r_cnt  <= '0;
      r_sclk <= 1'b0;
    end else begin
      r_cnt <= w_tick ? '0 : r_cnt + 1'b1;
      if (w_tick && i_shift) r_sclk <= ~r_sclk;
    end
  end
endmodule

// File: rtl/spi_master_ctrl.sv
// spi_master_ctrl: SPI mode-0 master with a valid/ready word interface.
// Defining SPI_MASTER_LSB_FIRST_EN adds a per-transfer lsb_first select.
module spi_master_ctrl
  import spi_master_ctrl_pkg::*;
#(
  parameter int DATA_W  = DEF_DATA_W,
  parameter int CLK_DIV = DEF_CLK_DIV
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              tx_valid,
  output logic              tx_ready,
  input  logic [DATA_W-1:0] tx_data,
`ifdef SPI_MASTER_LSB_FIRST_EN
  input  logic              lsb_first,
`endif
  output logic              rx_valid,
  output logic [DATA_W-1:0] rx_data,
  output logic              busy,
  output logic              cs,
  output logic              sclk,
  output logic              mosi,
  input  logic              miso
);
  localparam int BW = $clog2(DATA_W + 1);
  state_t            r_state, w_next;
  logic [DATA_W-1:0] r_tx, r_rx, r_rx_data;
  logic [BW-1:0]     r_bits;
  logic              r_lsb, r_mosi, r_rx_valid;
  logic              w_lsb_in, w_accept, w_tick, w_rise, w_fall, w_last;
`ifdef SPI_MASTER_LSB_FIRST_EN
  assign w_lsb_in = lsb_first;
`else
  assign w_lsb_in = 1'b0;
`endif
  spi_clk_div #(.CLK_DIV(CLK_DIV)) u_div (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_en       (r_state != S_IDLE),
    .i_shift    (r_state == S_SHIFT),
    .o_tick     (w_tick),
    .o_rise_stb (w_rise),
    .o_fall_stb (w_fall),
    .o_sclk     (sclk)
  );
  assign tx_ready = (r_state == S_IDLE);
  assign busy     = !tx_ready;
  assign w_accept = tx_valid && tx_ready;
  assign cs       = (r_state == S_IDLE) || (r_state == S_GAP);
  assign mosi     = r_mosi;
  assign rx_valid = r_rx_valid;
  assign rx_data  = r_rx_data;
  assign w_last   = (r_bits == BW'(DATA_W - 1));
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  w_next = w_accept ? S_LEAD : S_IDLE;
      S_LEAD:  w_next = w_tick ? S_SHIFT : S_LEAD;
      S_SHIFT: w_next = (w_fall && w_last) ? S_TRAIL : S_SHIFT;
      S_TRAIL: w_next = w_tick ? S_GAP : S_TRAIL;
      S_GAP:   w_next = w_tick ? S_IDLE : S_GAP;
      default: w_next = S_IDLE;
    endcase
  end
  // The last falling edge leaves mosi alone; it is parked low when cs rises.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tx       <= '0;
      r_rx       <= '0;
      r_rx_data  <= '0;
      r_rx_valid <= 1'b0;
      r_mosi     <= 1'b0;
      r_bits     <= '0;
      r_lsb      <= 1'b0;
    end else begin
      r_rx_valid <= 1'b0;
      if (w_accept) begin
        r_tx   <= tx_data;
        r_lsb  <= w_lsb_in;
        r_mosi <= w_lsb_in ? tx_data[0] : tx_data[DATA_W-1];
        r_bits <= '0;
      end
      if (w_rise) r_rx <= r_lsb ? {miso, r_rx[DATA_W-1:1]} : {r_rx[DATA_W-2:0], miso};
      if (w_fall) begin
        r_bits <= r_bits + 1'b1;
        if (!w_last) begin
          r_tx   <= r_lsb ? (r_tx >> 1) : (r_tx << 1);
          r_mosi <= r_lsb ? r_tx[1] : r_tx[DATA_W-2];
        end
      end
      if (r_state == S_TRAIL && w_tick) begin
        r_rx_valid <= 1'b1;
        r_rx_data  <= r_rx;
        r_mosi     <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_spi_master_ctrl.sv
// tb_spi_master_ctrl: directed and randomized loopback transfers checked
// against a word-level model of the SPI master.
module tb_spi_master_ctrl;
  import spi_master_ctrl_pkg::*;
  localparam int W       = DEF_DATA_W;
  localparam int D       = DEF_CLK_DIV;
  localparam int LAT     = (2 * W + 2) * D;
  localparam int SPACING = (2 * W + 3) * D;

  logic         clk = 1'b0, rst_n = 1'b1, tx_valid = 1'b0, lsb_first = 1'b0, miso_zero = 1'b0;
  logic [W-1:0] tx_data = '0;
  logic         tx_ready, rx_valid, busy, cs, sclk, mosi, miso;
  logic [W-1:0] rx_data;
  int           n_chk = 0, n_pass = 0, cyc = 0, rises = 0, cs_low = 0, sclk_bad = 0, hi_run = 0, last_hi = 0;
  int           acc_cyc[$];
  logic [W-1:0] acc_q[$], rx_q[$];
  logic         mosi_q[$];

  always #5 clk = ~clk;
  assign miso = miso_zero ? 1'b0 : mosi;

  spi_master_ctrl #(.DATA_W(W), .CLK_DIV(D)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .tx_valid (tx_valid),
    .tx_ready (tx_ready),
    .tx_data  (tx_data),
`ifdef SPI_MASTER_LSB_FIRST_EN
    .lsb_first(lsb_first),
`endif
    .rx_valid (rx_valid),
    .rx_data  (rx_data),
    .busy     (busy),
    .cs       (cs),
    .sclk     (sclk),
    .mosi     (mosi),
    .miso     (miso)
  );

  always @(posedge clk) begin
    cyc++;
    if (tx_valid && tx_ready) begin
      acc_q.push_back(tx_data);
      acc_cyc.push_back(cyc);
    end
    if (rx_valid) rx_q.push_back(rx_data);
  end

  always @(posedge sclk) begin
    rises++;
    mosi_q.push_back(mosi);
  end

  always @(negedge clk) begin
    if (cs === 1'b0) begin
      cs_low++;
      if (hi_run > 0) last_hi = hi_run;
      hi_run = 0;
    end else begin
      hi_run++;
      if (sclk === 1'b1) sclk_bad++;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  function automatic logic [W-1:0] exp_stream(input logic [W-1:0] d, input logic lsb);
    logic [W-1:0] s;
    for (int i = 0; i < W; i++) s[W-1-i] = lsb ? d[i] : d[W-1-i];
    return s;
  endfunction

  function automatic logic [W-1:0] seen_stream();
    logic [W-1:0] s = '0;
    for (int i = 0; i < W && i < mosi_q.size(); i++) s[W-1-i] = mosi_q[i];
    return s;
  endfunction

  task automatic xfer(input logic [W-1:0] d, input logic lsb, output int lat);
    rises = 0;
    cs_low = 0;
    mosi_q.delete();
    check("ready_before_accept", 32'(tx_ready), 32'd1);
    tx_data = d;
    lsb_first = lsb;
    tx_valid = 1'b1;
    @(posedge clk); #1;
    tx_valid = 1'b0;
    tx_data = W'($urandom);
    lsb_first = ~lsb;
    lat = 999;
    for (int i = 1; i <= 200; i++) begin
      @(posedge clk); #1;
      if (rx_valid) begin
        lat = i;
        break;
      end
    end
    repeat (D + 1) @(posedge clk);
    #1;
  endtask

  task automatic check_xfer(input string tag, input logic [W-1:0] d, input logic lsb, input int lat);
    check({tag, "_latency"}, lat, LAT);
    check({tag, "_rx_data"}, 32'(rx_data), 32'(miso_zero ? W'(0) : d));
    check({tag, "_sclk_rises"}, rises, W);
    check({tag, "_cs_low_cycles"}, cs_low, LAT);
    check({tag, "_mosi_bits"}, 32'(seen_stream()), 32'(exp_stream(d, lsb)));
  endtask

  task automatic wait_acc(input int n);
    for (int i = 0; i < 400 && acc_q.size() < n; i++) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic wait_rx(input int n);
    for (int i = 0; i < 400 && rx_q.size() < n; i++) begin
      @(posedge clk); #1;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [W-1:0] d;
    logic         lsb;
    int           lat, a0, r0;
    #3 rst_n = 1'b0;
    #1;
    check("rst_cs", 32'(cs), 32'd1);
    check("rst_sclk", 32'(sclk), 32'd0);
    check("rst_mosi", 32'(mosi), 32'd0);
    check("rst_tx_ready", 32'(tx_ready), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_rx_valid", 32'(rx_valid), 32'd0);
    check("rst_rx_data", 32'(rx_data), 32'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;

    xfer(8'hA5, 1'b0, lat);
    check_xfer("a5", 8'hA5, 1'b0, lat);
    check("a5_idle_ready", 32'(tx_ready), 32'd1);
    check("a5_idle_cs", 32'(cs), 32'd1);

    a0 = acc_q.size();
    r0 = rx_q.size();
    tx_data = 8'h3C;
    tx_valid = 1'b1;
    wait_acc(a0 + 1);
    tx_data = 8'hC3;
    wait_acc(a0 + 2);
    tx_valid = 1'b0;
    wait_rx(r0 + 2);
    repeat (D + 2) @(posedge clk);
    #1;
    check("b2b_accepts", acc_q.size() - a0, 2);
    check("b2b_rx_count", rx_q.size() - r0, 2);
    check("b2b_rx0", 32'(rx_q.size() > r0 ? rx_q[r0] : W'(0)), 32'h3C);
    check("b2b_rx1", 32'(rx_q.size() > r0 + 1 ? rx_q[r0+1] : W'(0)), 32'hC3);
    check("b2b_spacing_ok", 32'(acc_cyc.size() >= a0 + 2 && acc_cyc[a0+1] - acc_cyc[a0] >= SPACING), 32'd1);
    check("b2b_cs_gap_ok", 32'(last_hi >= D), 32'd1);

    d = W'($urandom);
    a0 = acc_q.size();
    r0 = rx_q.size();
    rises = 0;
    tx_data = d;
    tx_valid = 1'b1;
    @(posedge clk); #1;
    tx_valid = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    tx_valid = 1'b1;
    tx_data = ~d;
    @(posedge clk); #1;
    tx_valid = 1'b0;
    repeat (150) @(posedge clk);
    #1;
    check("busy_accepts", acc_q.size() - a0, 1);
    check("busy_rx_count", rx_q.size() - r0, 1);
    check("busy_rx_data", 32'(rx_q.size() > r0 ? rx_q[r0] : W'(0)), 32'(d));
    check("busy_sclk_rises", rises, W);

    r0 = rx_q.size();
    rises = 0;
    tx_data = W'($urandom);
    tx_valid = 1'b1;
    @(posedge clk); #1;
    tx_valid = 1'b0;
    for (int i = 0; i < 200 && rises < 3; i++) begin
      @(posedge clk); #1;
    end
    check("rstmid_reached_3_rises", rises, 3);
    #2 rst_n = 1'b0;
    #1;
    check("rstmid_cs", 32'(cs), 32'd1);
    check("rstmid_sclk", 32'(sclk), 32'd0);
    check("rstmid_mosi", 32'(mosi), 32'd0);
    check("rstmid_tx_ready", 32'(tx_ready), 32'd1);
    check("rstmid_busy", 32'(busy), 32'd0);
    check("rstmid_rx_valid", 32'(rx_valid), 32'd0);
    #1 rst_n = 1'b1;
    repeat (100) @(posedge clk);
    #1;
    check("rstmid_no_rx_valid", rx_q.size() - r0, 0);
    xfer(8'h81, 1'b0, lat);
    check_xfer("after_rst", 8'h81, 1'b0, lat);

`ifdef SPI_MASTER_LSB_FIRST_EN
    xfer(8'h01, 1'b1, lat);
    check_xfer("lsb01", 8'h01, 1'b1, lat);
    check("lsb01_first_mosi", 32'(mosi_q.size() > 0 ? mosi_q[0] : 1'b0), 32'd1);
    miso_zero = 1'b1;
    xfer(8'h01, 1'b1, lat);
    check_xfer("lsb01_miso0", 8'h01, 1'b1, lat);
    miso_zero = 1'b0;
`endif

    for (int k = 0; k < 6; k++) begin
      d = W'($urandom);
`ifdef SPI_MASTER_LSB_FIRST_EN
      lsb = 1'($urandom_range(0, 1));
`else
      lsb = 1'b0;
`endif
      miso_zero = ($urandom_range(0, 3) == 0);
      xfer(d, lsb, lat);
      check_xfer($sformatf("rand%0d", k), d, lsb, lat);
    end
    miso_zero = 1'b0;

    check("sclk_low_while_cs_high", sclk_bad, 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
